// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between two masters (A = i8080
// bridge, B = loader/debug). Each port latches its command on a req rising
// edge; a small FSM serialises the latched commands onto the controller and
// returns completion/read data to the issuing port.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin tie-break;
// default build uses fixed priority with A winning ties).

// Per-port command latch, busy/pending flag, overrun flag and read-data holder.
module sram_arb_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [7:0]  dataout,
  input  logic        load,      // capture rd_data for this port
  input  logic        complete,  // this port's command finishes now
  input  logic [7:0]  rd_data,
  output logic        pending,
  output logic        valid,
  output logic [7:0]  datain,
  output logic        overrun,
  output logic        cmd_read,
  output logic        cmd_write,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data
);
  logic req_q;
  logic rise;

  assign rise = req & ~req_q;

  // registered copy of req for rising-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= req;

  // command capture, completion pulse, overrun and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      valid     <= 1'b0;
      datain    <= 8'h00;
      overrun   <= 1'b0;
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= 16'h0000;
      cmd_data  <= 8'h00;
    end else begin
      valid <= complete;
      if (complete) begin
        pending <= 1'b0;
      end else if (rise && !pending) begin
        pending   <= 1'b1;
        cmd_read  <= read;
        cmd_write <= write;
        cmd_addr  <= addr;
        cmd_data  <= dataout;
      end
      // a new edge while still owning a command is dropped
      if (rise && pending) overrun <= 1'b1;
      if (load) datain <= rd_data;
    end
  end
endmodule

module sram_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_read,
  input  logic        a_write,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_dataout,
  output logic        a_busy,
  output logic        a_valid,
  output logic [7:0]  a_datain,
  output logic        a_overrun,
  input  logic        b_req,
  input  logic        b_read,
  input  logic        b_write,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_dataout,
  output logic        b_busy,
  output logic        b_valid,
  output logic [7:0]  b_datain,
  output logic        b_overrun,
  output logic        sram_req,
  output logic        sram_read,
  output logic        sram_write,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_dataout,
  input  logic [7:0]  sram_datain,
  input  logic        sram_valid,
  input  logic        sram_busy,
  output logic        grant_b
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] COMPLETE  = 3'd4;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam logic GRANT_RST = 1'b1;  // makes A win the first tie
`else
  localparam logic GRANT_RST = 1'b0;
`endif

  // index 0 = port A, index 1 = port B
  logic [1:0]       p_req, p_read, p_write, p_pend, p_valid, p_ovr;
  logic [1:0]       p_cread, p_cwrite, p_load, p_done, owner_oh;
  logic [1:0][15:0] p_addr, p_caddr;
  logic [1:0][7:0]  p_dout, p_din, p_cdata;

  logic [2:0] state;
  logic [1:0] wait_cnt;
  logic       forced;   // controller never went busy; finish without sram_valid
  logic       sel_b;
  logic       owner_rd;
  logic       finish;

  assign p_req   = {b_req, a_req};
  assign p_read  = {b_read, a_read};
  assign p_write = {b_write, a_write};
  assign p_addr  = {b_addr, a_addr};
  assign p_dout  = {b_dataout, a_dataout};

  assign a_busy    = p_pend[0];
  assign b_busy    = p_pend[1];
  assign a_valid   = p_valid[0];
  assign b_valid   = p_valid[1];
  assign a_datain  = p_din[0];
  assign b_datain  = p_din[1];
  assign a_overrun = p_ovr[0];
  assign b_overrun = p_ovr[1];

  for (genvar i = 0; i < 2; i++) begin : g_port
    sram_arb_port u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (p_req[i]),
      .read     (p_read[i]),
      .write    (p_write[i]),
      .addr     (p_addr[i]),
      .dataout  (p_dout[i]),
      .load     (p_load[i]),
      .complete (p_done[i]),
      .rd_data  (sram_datain),
      .pending  (p_pend[i]),
      .valid    (p_valid[i]),
      .datain   (p_din[i]),
      .overrun  (p_ovr[i]),
      .cmd_read (p_cread[i]),
      .cmd_write(p_cwrite[i]),
      .cmd_addr (p_caddr[i]),
      .cmd_data (p_cdata[i])
    );
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  assign sel_b = p_pend[1] & (~p_pend[0] | ~grant_b);
`else
  assign sel_b = ~p_pend[0];
`endif

  assign owner_oh = {grant_b, ~grant_b};
  assign owner_rd = p_cread[grant_b];
  // writes finish on busy low; reads also need sram_valid unless timed out
  assign finish   = (state == WAIT_DONE) & ~sram_busy & (forced | ~owner_rd | sram_valid);
  // only reads update the owner's datain, so a port never sees foreign data
  assign p_load   = {2{finish & owner_rd}} & owner_oh;
  assign p_done   = {2{state == COMPLETE}} & owner_oh;

  // arbitration and SRAM command sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant_b      <= GRANT_RST;
      sram_req     <= 1'b0;
      sram_read    <= 1'b0;
      sram_write   <= 1'b0;
      sram_addr    <= 16'h0000;
      sram_dataout <= 8'h00;
      wait_cnt     <= 2'd0;
      forced       <= 1'b0;
    end else begin
      sram_req   <= 1'b0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      case (state)
        IDLE: if (|p_pend && !sram_busy) begin
          grant_b      <= sel_b;
          sram_req     <= 1'b1;
          sram_read    <= p_cread[sel_b];
          sram_write   <= p_cwrite[sel_b];
          sram_addr    <= p_caddr[sel_b];
          sram_dataout <= p_cdata[sel_b];
          state        <= ISSUE;
        end
        ISSUE: begin
          wait_cnt <= 2'd0;
          forced   <= 1'b0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (sram_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == 2'd3) begin
            forced <= 1'b1;
            state  <= WAIT_DONE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        WAIT_DONE: if (finish) state <= COMPLETE;
        COMPLETE:  state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a small behavioural SRAM controller.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_read = 1'b0, a_write = 1'b0;
  logic [15:0] a_addr = 16'h0;
  logic [7:0]  a_dataout = 8'h0;
  logic        b_req = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [15:0] b_addr = 16'h0;
  logic [7:0]  b_dataout = 8'h0;
  logic        a_busy, a_valid, a_overrun, b_busy, b_valid, b_overrun;
  logic [7:0]  a_datain, b_datain;
  logic        sram_req, sram_read, sram_write, grant_b;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dataout, sram_datain;
  logic        sram_busy = 1'b0, sram_valid = 1'b0;

  // controller model state
  logic [7:0]  m_rdata = 8'h00;
  logic        m_silent = 1'b0;
  logic [1:0]  m_cnt = 2'd0;
  logic        m_rd = 1'b0;
  int          m_overlap = 0;

  // monitors
  logic [15:0] iss_addr[$];
  logic        iss_rd[$], iss_wr[$];
  logic [7:0]  iss_dat[$];
  int          a_vcnt = 0, b_vcnt = 0;

  int checks = 0, errors = 0;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam logic        GRANT_RST  = 1'b1;
  localparam logic [15:0] FIRST_ADDR = 16'h0020;
  localparam logic [15:0] SECOND_ADDR = 16'h0010;
`else
  localparam logic        GRANT_RST  = 1'b0;
  localparam logic [15:0] FIRST_ADDR = 16'h0010;
  localparam logic [15:0] SECOND_ADDR = 16'h0020;
`endif

  assign sram_datain = m_rdata;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_read(a_read), .a_write(a_write), .a_addr(a_addr), .a_dataout(a_dataout),
    .a_busy(a_busy), .a_valid(a_valid), .a_datain(a_datain), .a_overrun(a_overrun),
    .b_req(b_req), .b_read(b_read), .b_write(b_write), .b_addr(b_addr), .b_dataout(b_dataout),
    .b_busy(b_busy), .b_valid(b_valid), .b_datain(b_datain), .b_overrun(b_overrun),
    .sram_req(sram_req), .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
    .sram_dataout(sram_dataout), .sram_datain(sram_datain), .sram_valid(sram_valid),
    .sram_busy(sram_busy), .grant_b(grant_b)
  );

  // SRAM controller: busy the edge after req, three busy cycles, then valid for reads
  always @(posedge clk) begin
    sram_valid <= 1'b0;
    if (sram_req) begin
      if (sram_busy) m_overlap <= m_overlap + 1;
      if (!m_silent) begin
        sram_busy <= 1'b1;
        m_cnt     <= 2'd2;
        m_rd      <= sram_read;
      end
    end else if (sram_busy) begin
      if (m_cnt == 2'd0) begin
        sram_busy  <= 1'b0;
        sram_valid <= m_rd;
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  // log every issued command and every valid cycle
  always @(posedge clk) begin
    if (sram_req) begin
      iss_addr.push_back(sram_addr);
      iss_rd.push_back(sram_read);
      iss_wr.push_back(sram_write);
      iss_dat.push_back(sram_dataout);
    end
    if (a_valid) a_vcnt <= a_vcnt + 1;
    if (b_valid) b_vcnt <= b_vcnt + 1;
  end

  task automatic a_cmd(input logic rd, input logic [15:0] ad, input logic [7:0] d);
    a_read = rd; a_write = ~rd; a_addr = ad; a_dataout = d; a_req = 1'b1;
  endtask

  task automatic b_cmd(input logic rd, input logic [15:0] ad, input logic [7:0] d);
    b_read = rd; b_write = ~rd; b_addr = ad; b_dataout = d; b_req = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while ((a_busy || b_busy) && n < 100) begin @(negedge clk); n++; end
    ok = !(a_busy || b_busy);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_busy, b_busy, a_valid, b_valid, a_overrun, b_overrun} !== 6'b0) begin
      errors++; $display("FAIL reset_port_flags: got %b, expected 000000",
                         {a_busy, b_busy, a_valid, b_valid, a_overrun, b_overrun});
    end
    checks++;
    if ({a_datain, b_datain} !== 16'h0) begin
      errors++; $display("FAIL reset_datain: got %h, expected 0000", {a_datain, b_datain});
    end
    checks++;
    if ({sram_req, sram_read, sram_write, sram_addr, sram_dataout} !== 27'h0) begin
      errors++; $display("FAIL reset_sram: got %h, expected 0",
                         {sram_req, sram_read, sram_write, sram_addr, sram_dataout});
    end
    checks++;
    if (grant_b !== GRANT_RST) begin
      errors++; $display("FAIL reset_grant_b: got %b, expected %b", grant_b, GRANT_RST);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_a_read;
    int n0, va, vb, n;
    n0 = iss_addr.size(); va = a_vcnt; vb = b_vcnt;
    m_rdata = 8'h5A;
    a_cmd(1'b1, 16'h1234, 8'h00);
    @(negedge clk); a_req = 1'b0;
    checks++;
    if ({a_busy, sram_req} !== 2'b10) begin
      errors++; $display("FAIL a_read_capture: busy/req got %b, expected 10", {a_busy, sram_req});
    end
    @(negedge clk);
    checks++;
    if ({sram_req, sram_read, sram_write, sram_addr} !== {3'b110, 16'h1234}) begin
      errors++; $display("FAIL a_read_issue: got %b %h, expected 110 1234",
                         {sram_req, sram_read, sram_write}, sram_addr);
    end
    @(negedge clk);
    checks++;
    if ({sram_req, sram_read, sram_write} !== 3'b000) begin
      errors++; $display("FAIL a_read_issue_len: got %b, expected 000", {sram_req, sram_read, sram_write});
    end
    n = 3;
    while (!a_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n !== 8) begin
      errors++; $display("FAIL a_read_latency: valid at cycle %0d, expected 8", n);
    end
    checks++;
    if ({a_datain, a_busy, grant_b, b_valid} !== {8'h5A, 3'b000}) begin
      errors++; $display("FAIL a_read_result: data %h busy %b grant %b b_valid %b, expected 5a 0 0 0",
                         a_datain, a_busy, grant_b, b_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (iss_addr.size() - n0 !== 1 || a_vcnt - va !== 1 || b_vcnt - vb !== 0) begin
      errors++; $display("FAIL a_read_counts: issues %0d a_valid %0d b_valid %0d, expected 1 1 0",
                         iss_addr.size() - n0, a_vcnt - va, b_vcnt - vb);
    end
  endtask

  task automatic test_b_write;
    int n0, va, vb, n;
    n0 = iss_addr.size(); va = a_vcnt; vb = b_vcnt;
    m_rdata = 8'hEE;
    b_cmd(1'b0, 16'h0100, 8'hC3);
    @(negedge clk); b_req = 1'b0;
    n = 1;
    while (!b_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if ({b_valid, b_busy, grant_b} !== 3'b101) begin
      errors++; $display("FAIL b_write_done: valid/busy/grant got %b, expected 101", {b_valid, b_busy, grant_b});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (iss_addr.size() - n0 !== 1) begin
      errors++; $display("FAIL b_write_issues: got %0d, expected 1", iss_addr.size() - n0);
    end else begin
      checks++;
      if ({iss_rd[n0], iss_wr[n0], iss_addr[n0], iss_dat[n0]} !== {2'b01, 16'h0100, 8'hC3}) begin
        errors++; $display("FAIL b_write_cmd: got %b %h %h, expected 01 0100 c3",
                           {iss_rd[n0], iss_wr[n0]}, iss_addr[n0], iss_dat[n0]);
      end
    end
    checks++;
    if (b_vcnt - vb !== 1 || a_vcnt - va !== 0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL b_write_counts: b_valid %0d a_valid %0d b_busy %b, expected 1 0 0",
                         b_vcnt - vb, a_vcnt - va, b_busy);
    end
  endtask

  task automatic test_held_req;
    int n0, va, n;
    n0 = iss_addr.size(); va = a_vcnt;
    m_rdata = 8'h99;
    a_cmd(1'b1, 16'h0042, 8'h00);
    n = 0;
    while (!a_valid && n < 40) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    a_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (iss_addr.size() - n0 !== 1 || a_vcnt - va !== 1) begin
      errors++; $display("FAIL held_req_once: issues %0d valids %0d, expected 1 1",
                         iss_addr.size() - n0, a_vcnt - va);
    end
    checks++;
    if ({a_datain, a_overrun, a_busy} !== {8'h99, 2'b00}) begin
      errors++; $display("FAIL held_req_state: data %h overrun %b busy %b, expected 99 0 0",
                         a_datain, a_overrun, a_busy);
    end
  endtask

  task automatic test_overrun;
    int n0;
    bit ok;
    n0 = iss_addr.size();
    m_rdata = 8'h21;
    a_cmd(1'b1, 16'h0050, 8'h00);
    @(negedge clk); a_req = 1'b0;
    @(negedge clk); a_cmd(1'b1, 16'h0060, 8'h00);
    @(negedge clk); a_req = 1'b0;
    checks++;
    if ({a_overrun, a_busy} !== 2'b11) begin
      errors++; $display("FAIL overrun_set: overrun/busy got %b, expected 11", {a_overrun, a_busy});
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL overrun_idle: still busy a=%b b=%b, expected idle", a_busy, b_busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (iss_addr.size() - n0 !== 1 || iss_addr[iss_addr.size() - 1] !== 16'h0050) begin
      errors++; $display("FAIL overrun_issues: %0d issues, last addr %h, expected 1 at 0050",
                         iss_addr.size() - n0, iss_addr[iss_addr.size() - 1]);
    end
    checks++;
    if ({a_datain, a_overrun, b_overrun} !== {8'h21, 2'b10}) begin
      errors++; $display("FAIL overrun_sticky: data %h a_ovr %b b_ovr %b, expected 21 1 0",
                         a_datain, a_overrun, b_overrun);
    end
  endtask

  task automatic test_simultaneous;
    int n0, va, vb;
    bit ok;
    n0 = iss_addr.size(); va = a_vcnt; vb = b_vcnt;
    m_rdata = 8'h3C;
    a_cmd(1'b1, 16'h0010, 8'h00);
    b_cmd(1'b0, 16'h0020, 8'h11);
    @(negedge clk); a_req = 1'b0; b_req = 1'b0;
    checks++;
    if ({a_busy, b_busy} !== 2'b11) begin
      errors++; $display("FAIL simul_capture: busy got %b, expected 11", {a_busy, b_busy});
    end
    wait_idle(ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL simul_idle: still busy a=%b b=%b, expected idle", a_busy, b_busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (iss_addr.size() - n0 !== 2) begin
      errors++; $display("FAIL simul_issues: got %0d, expected 2", iss_addr.size() - n0);
    end else begin
      checks++;
      if ({iss_addr[n0], iss_addr[n0 + 1]} !== {FIRST_ADDR, SECOND_ADDR}) begin
        errors++; $display("FAIL simul_order: got %h then %h, expected %h then %h",
                           iss_addr[n0], iss_addr[n0 + 1], FIRST_ADDR, SECOND_ADDR);
      end
    end
    checks++;
    if ({a_datain, b_datain} !== {8'h3C, 8'h00}) begin
      errors++; $display("FAIL simul_datain: a %h b %h, expected 3c 00", a_datain, b_datain);
    end
    checks++;
    if (a_vcnt - va !== 1 || b_vcnt - vb !== 1) begin
      errors++; $display("FAIL simul_valids: a %0d b %0d, expected 1 1", a_vcnt - va, b_vcnt - vb);
    end
  endtask

  task automatic test_timeout;
    int n0, n;
    n0 = iss_addr.size();
    m_silent = 1'b1;
    m_rdata  = 8'h77;
    a_cmd(1'b1, 16'h0300, 8'h00);
    @(negedge clk); a_req = 1'b0;
    n = 1;
    while (!a_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if ({a_valid, a_datain, a_busy} !== {1'b1, 8'h77, 1'b0}) begin
      errors++; $display("FAIL timeout_done: valid %b data %h busy %b, expected 1 77 0",
                         a_valid, a_datain, a_busy);
    end
    repeat (3) @(negedge clk);
    m_silent = 1'b0;
    checks++;
    if (iss_addr.size() - n0 !== 1) begin
      errors++; $display("FAIL timeout_issues: got %0d, expected 1", iss_addr.size() - n0);
    end
  endtask

  task automatic test_reset_mid;
    int n0, va, n;
    n0 = iss_addr.size(); va = a_vcnt;
    m_rdata = 8'h44;
    a_cmd(1'b1, 16'h0400, 8'h00);
    @(negedge clk); a_req = 1'b0;
    n = 0;
    while (!sram_busy && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, b_busy, a_valid, b_valid, a_overrun, b_overrun, sram_req, sram_read, sram_write, grant_b}
        !== {9'b0, GRANT_RST}) begin
      errors++; $display("FAIL reset_mid_flags: got %b, expected %b",
                         {a_busy, b_busy, a_valid, b_valid, a_overrun, b_overrun, sram_req, sram_read, sram_write, grant_b},
                         {9'b0, GRANT_RST});
    end
    checks++;
    if ({a_datain, b_datain, sram_addr, sram_dataout} !== 40'h0) begin
      errors++; $display("FAIL reset_mid_data: got %h, expected 0",
                         {a_datain, b_datain, sram_addr, sram_dataout});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (a_vcnt - va !== 0 || iss_addr.size() - n0 !== 1) begin
      errors++; $display("FAIL reset_mid_abandon: valids %0d issues %0d, expected 0 1",
                         a_vcnt - va, iss_addr.size() - n0);
    end
    m_rdata = 8'h66;
    a_cmd(1'b1, 16'h0500, 8'h00);
    @(negedge clk); a_req = 1'b0;
    n = 1;
    while (!a_valid && n < 40) begin @(negedge clk); n++; end
    checks++;
    if ({a_valid, a_datain} !== {1'b1, 8'h66}) begin
      errors++; $display("FAIL reset_mid_recover: valid %b data %h, expected 1 66", a_valid, a_datain);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a_vcnt - va !== 1 || iss_addr[iss_addr.size() - 1] !== 16'h0500) begin
      errors++; $display("FAIL reset_mid_counts: valids %0d last addr %h, expected 1 0500",
                         a_vcnt - va, iss_addr[iss_addr.size() - 1]);
    end
  endtask

  initial begin
    test_reset;
    test_a_read;
    test_b_write;
    test_held_req;
    test_overrun;
    test_simultaneous;
    test_timeout;
    test_reset_mid;
    checks++;
    if (m_overlap !== 0) begin
      errors++; $display("FAIL single_outstanding: %0d overlapping requests, expected 0", m_overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
